// File: rtl/seg_disp_to_bcd.sv
// seg_disp_to_bcd
// Reads a multiplexed 7-segment display back into BCD. Each edge registers
// {dig_sel, seg_in}. A digit's pattern is committed once it has stayed
// unchanged for STABLE_CNT samples. Legal glyphs are decoded into the slot
// picked by the one-hot dig_sel. When every slot has been filled, the frame is
// presented on a valid/ready handshake.
//
// Parameters:
//   DIGITS     number of multiplexed digits (1..8)
//   STABLE_CNT identical samples needed before a commit (1..15)
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   seg_in   {a,b,c,d,e,f,g,dp}, active-high
//   dig_sel  one-hot digit enable, bit i = digit i
//   bcd_out  captured digits, digit i at [4i+3:4i]
//   dp_out   captured decimal points
//   valid    frame complete; outputs are frozen while high
//   ready    consumer accepts the frame on valid && ready
//   err      one-cycle pulse when a stable pattern is not a legal glyph
// Build option:
//   SEG_ALT_GLYPH_EN  also accept the alternate 6 (1F), 7 (72) and 9 (73)
//
// FSM states:
//   state   | meaning
//   COLLECT | captures allowed, waiting for every slot to fill
//   FULL    | frame held on valid, captures blocked until accept

module seg_disp_to_bcd #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  err
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t                state, state_nxt;
    logic [DIGITS+7:0]     prev_q;
    logic [DIGITS+7:0]     cur;
    logic [3:0]            run_cnt, run_nxt;
    logic                  same;
    logic                  commit;
    logic                  onehot;
    logic                  legal;
    logic [3:0]            glyph_val;
    logic                  capture;
    logic                  bad_glyph;
    logic                  accept;
    logic [DIGITS-1:0]     fill_mask, fill_nxt;

    // Run counter: a run that has already reached STABLE_CNT stays there, so
    // a commit fires only on the edge where the count first arrives.
    always_comb begin
        cur  = {dig_sel, seg_in};
        same = (cur == prev_q);
        if (!same)
            run_nxt = 4'd1;
        else if (run_cnt >= STABLE)
            run_nxt = run_cnt;
        else
            run_nxt = run_cnt + 4'd1;
        // With STABLE_CNT=1 every change of pattern is a fresh run that commits.
        commit = (run_nxt == STABLE) && (!same || (run_cnt != STABLE));
    end

    always_comb begin
        onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
    end

    // Glyph decode on {a..g}; dp (seg_in[0]) does not take part.
    always_comb begin
        legal     = 1'b1;
        glyph_val = 4'd0;
        case (seg_in[7:1])
            7'h7E: glyph_val = 4'd0;
            7'h30: glyph_val = 4'd1;
            7'h6D: glyph_val = 4'd2;
            7'h79: glyph_val = 4'd3;
            7'h33: glyph_val = 4'd4;
            7'h5B: glyph_val = 4'd5;
            7'h5F: glyph_val = 4'd6;
            7'h70: glyph_val = 4'd7;
            7'h7F: glyph_val = 4'd8;
            7'h7B: glyph_val = 4'd9;
`ifdef SEG_ALT_GLYPH_EN
            7'h1F: glyph_val = 4'd6;
            7'h72: glyph_val = 4'd7;
            7'h73: glyph_val = 4'd9;
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        accept    = (state == FULL) && ready;
        // Blanking, multi-select and a frozen frame silently drop the commit.
        capture   = commit && onehot && (state == COLLECT) && legal &&
                    ((dig_sel & ~fill_mask) != '0);
        bad_glyph = commit && onehot && (state == COLLECT) && !legal;
        fill_nxt  = fill_mask;
        if (accept)
            fill_nxt = '0;
        else if (capture)
            fill_nxt = fill_mask | dig_sel;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (&fill_nxt) state_nxt = FULL;
            FULL:    if (accept)    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        valid = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            run_cnt   <= '0;
            fill_mask <= '0;
            err       <= 1'b0;
        end else begin
            prev_q    <= cur;
            run_cnt   <= run_nxt;
            fill_mask <= fill_nxt;
            err       <= bad_glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out <= '0;
            dp_out  <= '0;
        end else if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (dig_sel[i]) begin
                    bcd_out[4*i +: 4] <= glyph_val;
                    dp_out[i]         <= seg_in[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_to_bcd.sv
module tb_seg_disp_to_bcd;

    localparam int DIGITS = 4;
    localparam int S      = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           seg_in;
    logic [DIGITS-1:0]    dig_sel;
    logic [4*DIGITS-1:0]  bcd_out;
    logic [DIGITS-1:0]    dp_out;
    logic                 valid;
    logic                 ready;
    logic                 err;

    seg_disp_to_bcd #(.DIGITS(DIGITS), .STABLE_CNT(S)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
        .bcd_out(bcd_out), .dp_out(dp_out), .valid(valid),
        .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] glyph_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    function automatic int glyph_value(input logic [6:0] g);
        for (int i = 0; i < 10; i++)
            if (glyph_tab[i] == g) return i;
`ifdef SEG_ALT_GLYPH_EN
        if (g == 7'h1F) return 6;
        if (g == 7'h72) return 7;
        if (g == 7'h73) return 9;
`endif
        return -1;
    endfunction

    logic [19:0]  exp_q[$];        // {dp, bcd} of each completed frame
    int           err_exp  = 0;
    int           err_seen = 0;
    logic [15:0]  m_bcd;
    logic [3:0]   m_dp;
    logic [3:0]   m_fill;
    bit           m_full;
    logic [11:0]  m_last;
    int           m_run;

    task automatic model_reset();
        m_bcd = '0; m_dp = '0; m_fill = '0; m_full = 0;
        m_last = '0; m_run = 0;
        exp_q.delete();
    endtask

    // Present {dsel, seg} for len cycles; ready is high only on the last one.
    task automatic hold(input logic [3:0] dsel, input logic [7:0] seg,
                        input int len, input bit rdy);
        logic [11:0] p;
        int  old_run, slot, v, commit_at;
        bit  do_commit;
        p       = {dsel, seg};
        old_run = (p == m_last) ? m_run : 0;
        do_commit = (old_run < S) && (old_run + len >= S);
        commit_at = S - old_run;
        m_last  = p;
        m_run   = (old_run + len > 100) ? 100 : old_run + len;

        if (m_full) begin
            if (rdy) begin m_full = 0; m_fill = '0; end
        end else begin
            if (do_commit && $countones(dsel) == 1) begin
                slot = 0;
                for (int i = 0; i < DIGITS; i++) if (dsel[i]) slot = i;
                v = glyph_value(seg[7:1]);
                if (v < 0) err_exp++;
                else if (!m_fill[slot]) begin
                    m_bcd[4*slot +: 4] = 4'(v);
                    m_dp[slot]         = seg[0];
                    m_fill[slot]       = 1'b1;
                    if (&m_fill) begin
                        m_full = 1;
                        exp_q.push_back({m_dp, m_bcd});
                    end
                end
            end
            if (rdy && m_full && commit_at < len) begin
                m_full = 0; m_fill = '0;
            end
        end

        for (int c = 1; c <= len; c++) begin
            dig_sel = dsel;
            seg_in  = seg;
            ready   = rdy && (c == len);
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
    endtask

    function automatic logic [7:0] gseg(input int d, input bit dp);
        logic [6:0] g;
        g = glyph_tab[d];
        return {g, dp};
    endfunction

    // ---------------- monitor ----------------
    bit pv = 0, perr = 0;
    logic [19:0] e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0; perr = 0;
            end else begin
                if (valid && !pv)
                    check("valid_rise_expected", 32'(exp_q.size() > 0), 32'd1);
                if (valid && ready) begin
                    if (exp_q.size() == 0)
                        check("accept_without_frame", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("frame_bcd", 32'(bcd_out), 32'(e[15:0]));
                        check("frame_dp", 32'(dp_out), 32'(e[19:16]));
                    end
                end
                if (err) begin
                    err_seen++;
                    check("err_single_cycle", 32'(perr), 32'd0);
                end
                pv = valid; perr = err;
            end
        end
    end

    // ---------------- stimulus ----------------
    int r;
    logic [3:0] ds;
    logic [7:0] sg;
    initial begin
        rst = 1'b1; seg_in = '0; dig_sel = '0; ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_dp", 32'(dp_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Scan 0..3, ready low: frame completes on the third sample of digit 3.
        for (int d = 0; d < 4; d++) hold(4'(1 << d), gseg(d, 0), 3, 0);
        check("scan_valid", 32'(valid), 32'd1);
        check("scan_bcd", 32'(bcd_out), 32'h3210);
        check("scan_dp", 32'(dp_out), 32'd0);
        hold(4'b0000, 8'h00, 4, 0);
        check("valid_holds", 32'(valid), 32'd1);

        // Accept on the same edge a digit 0 glyph completes its run.
        hold(4'b0001, gseg(7, 0), 3, 1);
        check("collide_valid", 32'(valid), 32'd0);
        hold(4'b0001, gseg(7, 0), 2, 0);   // same run continues: no recommit

        // Short run on digit 1 does not commit; later full hold does.
        hold(4'b0010, gseg(5, 1), 2, 0);
        hold(4'b0001, gseg(9, 0), 3, 0);
        hold(4'b0010, gseg(5, 1), 3, 0);
        // Illegal glyph on digit 2, then a legal 8.
        hold(4'b0100, 8'h90, 3, 0);
        check("illegal_err", 32'(err), 32'd1);
        hold(4'b0100, 8'h90, 1, 0);
        check("illegal_err_drop", 32'(err), 32'd0);
        check("illegal_no_frame", 32'(valid), 32'd0);
        hold(4'b0100, gseg(8, 0), 3, 0);
        // Multi-select and blanking: nothing happens.
        hold(4'b0011, gseg(4, 0), 4, 0);
        hold(4'b0000, gseg(4, 0), 4, 0);
        check("blank_no_err", 32'(err), 32'd0);
        hold(4'b1000, gseg(2, 1), 3, 0);
        check("second_frame_bcd", 32'(bcd_out), 32'h2859);
        check("second_frame_dp", 32'(dp_out), 32'h2 | 32'h8);
        hold(4'b0000, 8'h00, 1, 1);

        // Alternate tail-less 6 on digit 0, then reset mid-frame.
        hold(4'b0001, 8'h3E, 3, 0);
        hold(4'b0010, gseg(1, 1), 3, 0);
        hold(4'b0000, 8'h00, 1, 0);
        rst = 1'b1; dig_sel = '0; seg_in = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("midrst_bcd", 32'(bcd_out), 32'd0);
        check("midrst_dp", 32'(dp_out), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        rst = 1'b0;

        // Random phase.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      ds = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) ds = 4'b0000;
            else             ds = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) < 6)
                sg = gseg($urandom_range(0, 9), 1'($urandom_range(0, 1)));
            else
                sg = 8'($urandom_range(0, 255));
            hold(ds, sg, $urandom_range(1, 5),
                 m_full ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0));
        end
        if (m_full) hold(4'b0000, 8'h00, 1, 1);
        hold(4'b0000, 8'h00, 3, 0);

        check("frames_drained", 32'(exp_q.size()), 32'd0);
        check("err_count", 32'(err_seen), 32'(err_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
